// File: rtl/width_adapter_pipe.sv
// Multi-lane width converter (zero/sign extend, saturate, truncate) behind a
// valid/ready pipeline with a main output register and a one-entry skid register.
module width_adapter_pipe #(
    parameter int IN_W  = 18,
    parameter int OUT_W = 32,
    parameter int LANES = 4,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*IN_W-1:0]  in_data,
    input  logic [1:0]             in_mode,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       sat_lanes,
    output logic [CNT_W-1:0]       sat_count,
    input  logic                   clr_stats
);

    logic [LANES*OUT_W-1:0] conv_data;
    logic [LANES-1:0]       conv_sat;
    logic [LANES*OUT_W-1:0] s_data;
    logic                   s_valid;
    logic                   accept;
    logic                   drain;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [IN_W-1:0] x;
        assign x = in_data[k*IN_W +: IN_W];

        if (OUT_W >= IN_W) begin : g_wide
            // Widening never saturates; truncate and zero-extend coincide here.
            assign conv_data[k*OUT_W +: OUT_W] =
                (in_mode == 2'd1) ? OUT_W'($signed(x)) : OUT_W'(x);
            assign conv_sat[k] = 1'b0;
        end else begin : g_narrow
            logic [IN_W-OUT_W-1:0] hi_z;
            logic [IN_W-OUT_W:0]   hi_s;
            logic                  z_ovf;
            logic                  s_ovf;
            logic [OUT_W-1:0]      y;
            logic                  sat;

            assign hi_z  = x[IN_W-1:OUT_W];
            assign hi_s  = x[IN_W-1:OUT_W-1];
            assign z_ovf = |hi_z;
            // Signed value fits only when the dropped bits all copy the new sign bit.
            assign s_ovf = ~((&hi_s) | ~(|hi_s));

            always_comb begin
                y   = x[OUT_W-1:0];
                sat = 1'b0;
                case (in_mode)
                    2'd1: begin
                        if (s_ovf) begin
                            sat = 1'b1;
                            y   = x[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                                            : {1'b0, {(OUT_W-1){1'b1}}};
                        end
                    end
                    2'd2: ;
                    default: begin
                        if (z_ovf) begin
                            sat = 1'b1;
                            y   = '1;
                        end
                    end
                endcase
            end

            assign conv_data[k*OUT_W +: OUT_W] = y;
            assign conv_sat[k] = sat;
        end
    end

    assign in_ready = ~s_valid;
    assign accept   = in_valid & ~s_valid;
    assign drain    = out_valid & out_ready;

    // Main register refills from skid first, so ordering is preserved.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            s_valid   <= 1'b0;
            s_data    <= '0;
        end else begin
            if (!out_valid || drain) begin
                if (s_valid) begin
                    out_data  <= s_data;
                    out_valid <= 1'b1;
                    s_valid   <= 1'b0;
                end else if (accept) begin
                    out_data  <= conv_data;
                    out_valid <= 1'b1;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (accept) begin
                s_data  <= conv_data;
                s_valid <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sat_lanes <= '0;
            sat_count <= '0;
        end else if (clr_stats) begin
            sat_lanes <= '0;
            sat_count <= '0;
        end else if (accept) begin
            sat_lanes <= sat_lanes | conv_sat;
            if ((|conv_sat) && (sat_count != '1)) begin
                sat_count <= sat_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_width_adapter_pipe.sv
// Bench for width_adapter_pipe: a widening (18->32) and a narrowing (18->16,
// 4-bit counter) instance share stimulus and are checked against a queue model.
module tb_width_adapter_pipe;

    localparam int IN_W  = 18;
    localparam int LANES = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         out_ready;
    logic         clr_stats;
    logic [71:0]  in_data;
    logic [1:0]   in_mode;

    logic         in_ready_a, out_valid_a;
    logic [127:0] out_data_a;
    logic [3:0]   sat_lanes_a;
    logic [15:0]  sat_count_a;

    logic         in_ready_b, out_valid_b;
    logic [63:0]  out_data_b;
    logic [3:0]   sat_lanes_b;
    logic [3:0]   sat_count_b;

    int checks = 0;
    int errors = 0;

    logic [71:0] q_data[$];
    logic [1:0]  q_mode[$];
    logic [3:0]  m_lanes_a, m_lanes_b;
    int          m_count_a, m_count_b;
    bit          last_acc;

    always #5 clk = ~clk;

    width_adapter_pipe #(.IN_W(IN_W), .OUT_W(32), .LANES(LANES), .CNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_a),
        .out_ready(out_ready), .out_data(out_data_a), .sat_lanes(sat_lanes_a),
        .sat_count(sat_count_a), .clr_stats(clr_stats)
    );

    width_adapter_pipe #(.IN_W(IN_W), .OUT_W(16), .LANES(LANES), .CNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid_b),
        .out_ready(out_ready), .out_data(out_data_b), .sat_lanes(sat_lanes_b),
        .sat_count(sat_count_b), .clr_stats(clr_stats)
    );

    // Reference conversion done on integer values rather than bit slices.
    function automatic logic [31:0] conv(int w, logic [17:0] x, logic [1:0] mode,
                                         output bit sat);
        longint one = 1;
        longint u, s, r, lo, hi;
        int     tw;
        sat = 1'b0;
        u   = longint'(x);
        s   = x[17] ? u - (one << 18) : u;
        tw  = (w < 18) ? w : 18;
        case (mode)
            2'd2: r = u % (one << tw);
            2'd1: begin
                hi = (one << (w - 1)) - 1;
                lo = -(one << (w - 1));
                if (s > hi) begin r = hi; sat = 1'b1; end
                else if (s < lo) begin r = lo; sat = 1'b1; end
                else r = s;
            end
            default: begin
                if (u > (one << w) - 1) begin r = (one << w) - 1; sat = 1'b1; end
                else r = u;
            end
        endcase
        return 32'(r & ((one << w) - 1));
    endfunction

    function automatic logic [127:0] exp_vec(int w, logic [71:0] d, logic [1:0] mode);
        logic [127:0] r;
        bit s;
        r = '0;
        for (int k = 0; k < LANES; k++) begin
            r = r | (128'(conv(w, d[k*IN_W +: IN_W], mode, s)) << (k * w));
        end
        return r;
    endfunction

    function automatic logic [3:0] exp_sat(int w, logic [71:0] d, logic [1:0] mode);
        logic [3:0]  r;
        logic [31:0] v;
        bit s;
        for (int k = 0; k < LANES; k++) begin
            v    = conv(w, d[k*IN_W +: IN_W], mode, s);
            r[k] = s;
        end
        return r;
    endfunction

    function automatic logic [17:0] rand_lane();
        logic [17:0] v;
        case ($urandom_range(0, 5))
            0: v = 18'h3FFFF;
            1: v = 18'h20000;
            2: v = 18'h1FFFF;
            3: v = 18'h08000;
            4: v = 18'h07FFF;
            default: v = 18'($urandom);
        endcase
        return v;
    endfunction

    task automatic check_output(string tag, logic [127:0] obs, logic [127:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_all();
        check_output("in_ready_a", 128'(in_ready_a), 128'(q_data.size() < 2));
        check_output("in_ready_b", 128'(in_ready_b), 128'(q_data.size() < 2));
        check_output("out_valid_a", 128'(out_valid_a), 128'(q_data.size() > 0));
        check_output("out_valid_b", 128'(out_valid_b), 128'(q_data.size() > 0));
        if (q_data.size() > 0) begin
            check_output("out_data_a", out_data_a, exp_vec(32, q_data[0], q_mode[0]));
            check_output("out_data_b", 128'(out_data_b), exp_vec(16, q_data[0], q_mode[0]));
        end
        check_output("sat_lanes_a", 128'(sat_lanes_a), 128'(m_lanes_a));
        check_output("sat_lanes_b", 128'(sat_lanes_b), 128'(m_lanes_b));
        check_output("sat_count_a", 128'(sat_count_a), 128'(m_count_a));
        check_output("sat_count_b", 128'(sat_count_b), 128'(m_count_b));
    endtask

    // One clock: model occupancy decides accept/drain, then DUT is compared after the edge.
    task automatic apply_stimulus();
        bit         acc, drn;
        logic [3:0] sa, sb;
        acc = in_valid && (q_data.size() < 2);
        drn = out_ready && (q_data.size() > 0);
        sa  = exp_sat(32, in_data, in_mode);
        sb  = exp_sat(16, in_data, in_mode);
        @(posedge clk);
        #1;
        if (drn) begin
            void'(q_data.pop_front());
            void'(q_mode.pop_front());
        end
        if (acc) begin
            q_data.push_back(in_data);
            q_mode.push_back(in_mode);
        end
        if (clr_stats) begin
            m_lanes_a = '0; m_lanes_b = '0; m_count_a = 0; m_count_b = 0;
        end else if (acc) begin
            m_lanes_a = m_lanes_a | sa;
            m_lanes_b = m_lanes_b | sb;
            if ((|sa) && m_count_a < 65535) m_count_a++;
            if ((|sb) && m_count_b < 15) m_count_b++;
        end
        last_acc = acc;
        check_all();
    endtask

    task automatic model_reset();
        q_data.delete();
        q_mode.delete();
        m_lanes_a = '0; m_lanes_b = '0; m_count_a = 0; m_count_b = 0;
    endtask

    task automatic check_reset_state(string tag);
        check_output({tag, "_in_ready"}, 128'({in_ready_a, in_ready_b}), 128'(2'b11));
        check_output({tag, "_out_valid"}, 128'({out_valid_a, out_valid_b}), 128'(2'b00));
        check_output({tag, "_out_data_a"}, out_data_a, 128'(0));
        check_output({tag, "_out_data_b"}, 128'(out_data_b), 128'(0));
        check_output({tag, "_stats"},
                     128'({sat_lanes_a, sat_count_a, sat_lanes_b, sat_count_b}), 128'(0));
    endtask

    task automatic send_one(logic [71:0] d, logic [1:0] m);
        in_data  = d;
        in_mode  = m;
        in_valid = 1'b1;
        out_ready = 1'b1;
        apply_stimulus();
        in_valid = 1'b0;
    endtask

    initial begin
        logic [17:0] seen[$];
        int          beat;
        int          budget;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; clr_stats = 1'b0;
        in_data = '0; in_mode = 2'd0; last_acc = 1'b0;
        model_reset();
        #12;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Directed conversions.
        send_one({54'd0, 18'h3FFFF}, 2'd0);
        check_output("zext_a_lane0", 128'(out_data_a[31:0]), 128'(32'h0003FFFF));
        check_output("zext_a_count", 128'(sat_count_a), 128'(0));
        check_output("zext_b_lane0", 128'(out_data_b[15:0]), 128'(16'hFFFF));
        send_one({36'd0, 18'h20000, 18'd0}, 2'd1);
        check_output("sext_a_lane1", 128'(out_data_a[63:32]), 128'(32'hFFFE0000));
        send_one({36'd0, 18'h20000, 18'd0}, 2'd2);
        check_output("trunc_a_lane1", 128'(out_data_a[63:32]), 128'(32'h00020000));
        send_one({54'd0, 18'h1FFFF}, 2'd1);
        check_output("sext_b_pos_clamp", 128'(out_data_b[15:0]), 128'(16'h7FFF));
        send_one({54'd0, 18'h20000}, 2'd1);
        check_output("sext_b_neg_clamp", 128'(out_data_b[15:0]), 128'(16'h8000));
        send_one({54'd0, 18'h10000}, 2'd0);
        check_output("zext_b_sat", 128'(out_data_b[15:0]), 128'(16'hFFFF));
        send_one({54'd0, 18'h12345}, 2'd2);
        check_output("trunc_b", 128'(out_data_b[15:0]), 128'(16'h2345));
        send_one({54'd0, 18'h10000}, 2'd3);
        check_output("mode3_b", 128'(out_data_b[15:0]), 128'(16'hFFFF));
        out_ready = 1'b1;
        apply_stimulus();

        // Backpressure: beats 1..6, output stalled for three cycles.
        beat = 1;
        in_mode = 2'd2;
        in_valid = 1'b1;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_data = {4{18'(beat)}};
            apply_stimulus();
            if (last_acc) beat++;
        end
        check_output("bp_in_ready", 128'(in_ready_a), 128'(0));
        check_output("bp_hold_beat1", 128'(out_data_a[31:0]), 128'(1));
        out_ready = 1'b1;
        budget = 0;
        while (seen.size() < 6 && budget < 30) begin
            if (beat <= 6) begin
                in_data  = {4{18'(beat)}};
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid_a) seen.push_back(out_data_a[17:0]);
            apply_stimulus();
            if (last_acc) beat++;
            budget++;
        end
        check_output("bp_seen_count", 128'(seen.size()), 128'(6));
        for (int i = 0; i < seen.size(); i++) begin
            check_output("bp_order", 128'(seen[i]), 128'(i + 1));
        end
        check_output("bp_no_gaps", 128'(budget), 128'(6));
        in_valid = 1'b0;

        // Randomized traffic.
        for (int c = 0; c < 400; c++) begin
            in_valid  = 1'($urandom_range(0, 3) != 0);
            out_ready = 1'($urandom_range(0, 3) != 0);
            clr_stats = 1'($urandom_range(0, 24) == 0);
            in_mode   = 2'($urandom_range(0, 3));
            in_data   = {rand_lane(), rand_lane(), rand_lane(), rand_lane()};
            apply_stimulus();
        end
        clr_stats = 1'b0;

        // Counter saturation, then clear racing a saturating accept.
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_mode   = 2'd1;
        in_data   = {54'd0, 18'h20000};
        for (int c = 0; c < 20; c++) apply_stimulus();
        check_output("cnt_stick", 128'(sat_count_b), 128'(15));
        clr_stats = 1'b1;
        apply_stimulus();
        clr_stats = 1'b0;
        check_output("clr_wins_count", 128'(sat_count_b), 128'(0));
        check_output("clr_wins_lanes", 128'(sat_lanes_b), 128'(0));

        // Reset with both registers full.
        out_ready = 1'b0;
        in_mode   = 2'd0;
        in_data   = {4{18'h00123}};
        apply_stimulus();
        apply_stimulus();
        check_output("full_before_rst", 128'(in_ready_a), 128'(0));
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_state("midrst");
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        in_data   = {4{18'h00ABC}};
        apply_stimulus();
        check_output("post_rst_valid", 128'(out_valid_a), 128'(1));
        check_output("post_rst_data", 128'(out_data_a[31:0]), 128'(32'h00000ABC));
        in_valid = 1'b0;
        apply_stimulus();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
